// File: rtl/axil_pkg.sv
// Shared AXI4-lite constants and helpers for the on-chip RAM slave.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axil_pkg;

  localparam int AXIL_ADDR_W = 32;
  localparam int AXIL_DATA_W = 32;
  localparam int AXIL_STRB_W = AXIL_DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Width of a word index into a RAM of 'words' 32-bit entries.
  function automatic int word_idx_w(input int words);
    return (words < 2) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/axil_ram_core.sv
// Simple dual-port RAM: one byte-enabled write port, one synchronous read port.
// Latency: read data registered, valid the cycle after rd_en.
// Backpressure: none; rd_data holds its value while rd_en is low.
//
// Ports: clk/rst_n; wr_en, wr_idx, wr_strb, wr_data (write port);
//        rd_en, rd_idx, rd_data (read port). A read and a write to the same
//        index on the same edge return the old contents.
module axil_ram_core
  import axil_pkg::*;
#(
  parameter int    MEM_WORDS = 1024,
  parameter int    IDX_W     = 10,
  parameter string INIT_FILE = ""
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [AXIL_STRB_W-1:0] wr_strb,
  input  logic [AXIL_DATA_W-1:0] wr_data,
  input  logic                   rd_en,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [AXIL_DATA_W-1:0] rd_data
);

  logic [AXIL_DATA_W-1:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < AXIL_STRB_W; i++) begin
      if (wr_en && wr_strb[i]) mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
    end
  end

  // Non-blocking read of the pre-edge array gives read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/axil_ram_slave.sv
// AXI4-lite slave RAM with independent read/write channels and byte strobes.
// Latency: write commit -> bvalid next cycle; ar handshake -> rvalid next cycle.
// Backpressure: one outstanding per direction; readies held low until the response is accepted.
//
// Ports: clk, rsi_resetn (async active-low); AXI4-lite slave channels AW/W/B/AR/R
//        prefixed axs_. axs_awprot/axs_arprot are ignored.
// Build option: define AXIL_RAM_ERR_RESP_EN to answer out-of-range accesses with
//        SLVERR (writes dropped, reads return zero); otherwise addresses alias.
module axil_ram_slave
  import axil_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rsi_resetn,
  input  logic        axs_awvalid,
  output logic        axs_awready,
  input  logic [31:0] axs_awaddr,
  input  logic [2:0]  axs_awprot,
  input  logic        axs_wvalid,
  output logic        axs_wready,
  input  logic [31:0] axs_wdata,
  input  logic [3:0]  axs_wstrb,
  output logic        axs_bvalid,
  input  logic        axs_bready,
  output logic [1:0]  axs_bresp,
  input  logic        axs_arvalid,
  output logic        axs_arready,
  input  logic [31:0] axs_araddr,
  input  logic [2:0]  axs_arprot,
  output logic        axs_rvalid,
  input  logic        axs_rready,
  output logic [31:0] axs_rdata,
  output logic [1:0]  axs_rresp
);

  localparam int IW = word_idx_w(MEM_WORDS);
  localparam int HI = IW + 2;  // first byte-address bit above the RAM window

  // Readies stay low until one cycle after reset release.
  logic en;
  always_ff @(posedge clk or negedge rsi_resetn) begin
    if (!rsi_resetn) en <= 1'b0;
    else             en <= 1'b1;
  end

  // ---------------- write channel ----------------
  logic        aw_held, w_held;
  logic [31:0] aw_addr_q, w_data_q;
  logic [3:0]  w_strb_q;
  logic        aw_hs, w_hs, commit, wr_ok;
  logic [31:0] wr_addr, wr_data, wr_off;
  logic [3:0]  wr_strb;

  assign axs_awready = en & ~aw_held & ~axs_bvalid;
  assign axs_wready  = en & ~w_held  & ~axs_bvalid;
  assign aw_hs       = axs_awvalid & axs_awready;
  assign w_hs        = axs_wvalid  & axs_wready;
  // Commit as soon as both halves exist, whether just handshaken or latched earlier.
  assign commit      = (aw_held | aw_hs) & (w_held | w_hs);

  assign wr_addr = aw_held ? aw_addr_q : axs_awaddr;
  assign wr_data = w_held  ? w_data_q  : axs_wdata;
  assign wr_strb = w_held  ? w_strb_q  : axs_wstrb;
  assign wr_off  = wr_addr - BASE_ADDR;

`ifdef AXIL_RAM_ERR_RESP_EN
  assign wr_ok = (wr_off >> HI) == 32'd0;
`else
  assign wr_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rsi_resetn) begin
    if (!rsi_resetn) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= axs_awaddr;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= axs_wdata;
        w_strb_q <= axs_wstrb;
      end
    end
  end

  always_ff @(posedge clk or negedge rsi_resetn) begin
    if (!rsi_resetn) begin
      axs_bvalid <= 1'b0;
      axs_bresp  <= RESP_OKAY;
    end else if (commit) begin
      axs_bvalid <= 1'b1;
      axs_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (axs_bvalid && axs_bready) begin
      axs_bvalid <= 1'b0;
    end
  end

  // ---------------- read channel ----------------
  logic        ar_hs, rd_ok, rd_err_q;
  logic [31:0] rd_off, core_rdata;

  assign axs_arready = en & ~axs_rvalid;
  assign ar_hs       = axs_arvalid & axs_arready;
  assign rd_off      = axs_araddr - BASE_ADDR;

`ifdef AXIL_RAM_ERR_RESP_EN
  assign rd_ok = (rd_off >> HI) == 32'd0;
`else
  assign rd_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rsi_resetn) begin
    if (!rsi_resetn) begin
      axs_rvalid <= 1'b0;
      axs_rresp  <= RESP_OKAY;
      rd_err_q   <= 1'b0;
    end else if (ar_hs) begin
      axs_rvalid <= 1'b1;
      axs_rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      rd_err_q   <= ~rd_ok;
    end else if (axs_rvalid && axs_rready) begin
      axs_rvalid <= 1'b0;
    end
  end

  // The RAM register still captures an aliased word on an error read; mask it.
  assign axs_rdata = rd_err_q ? 32'h0000_0000 : core_rdata;

  axil_ram_core #(
    .MEM_WORDS (MEM_WORDS),
    .IDX_W     (IW),
    .INIT_FILE (INIT_FILE)
  ) u_core (
    .clk     (clk),
    .rst_n   (rsi_resetn),
    .wr_en   (commit & wr_ok),
    .wr_idx  (wr_off[HI-1:2]),
    .wr_strb (wr_strb),
    .wr_data (wr_data),
    .rd_en   (ar_hs),
    .rd_idx  (rd_off[HI-1:2]),
    .rd_data (core_rdata)
  );

  logic unused_bits;
  assign unused_bits = ^{axs_awprot, axs_arprot, wr_off, rd_off};

endmodule
